interrupt_acknowledge_sequencer: RTL and testbench
==================================================

INTERRUPT_ACKNOWLEDGE_SEQUENCER -- requirements
Module: interrupt_acknowledge_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clock and the reset port SHALL be named reset.
REQ-002 The block SHALL have no parameters.
REQ-003 The block SHALL have port clock  input  1  system clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port interrupt_request_register  input  8  pending requests, IR0..IR7.
REQ-006 The block SHALL have port interrupt_mask  input  8  1 = level masked.
REQ-007 The block SHALL have port priority_rotate  input  3  lowest-priority level.
REQ-008 The block SHALL have port interrupt_acknowledge_n  input  1  CPU INTA, active low, already synchronous to clock.
REQ-009 The block SHALL have port interrupt_vector_base  input  5  vector bits T7..T3.
REQ-010 The block SHALL have port auto_eoi_config  input  1  auto-EOI mode select.
REQ-011 The block SHALL have port end_of_interrupt  input  1  one-cycle EOI command strobe.
REQ-012 The block SHALL have port eoi_specific  input  1  1 = specific EOI using eoi_level.
REQ-013 The block SHALL have port eoi_level  input  3  level for specific EOI.
REQ-014 The block SHALL have port interrupt_to_cpu  output  1  INT request to CPU.
REQ-015 The block SHALL have port in_service_register  output  8  levels currently in service.
REQ-016 The block SHALL have port clear_interrupt_request  output  8  one-cycle one-hot clear to the request register.
REQ-017 The block SHALL have port data_bus_out  output  8  vector byte.
REQ-018 The block SHALL have port data_bus_out_enable  output  1  1 = data_bus_out valid and driven.

Function
REQ-019 Priority SHALL be rotating: level (priority_rotate+1) mod 8 is highest, and level priority_rotate is lowest.
REQ-020 The eligible set SHALL be interrupt_request_register & ~interrupt_mask.
REQ-021 The winner SHALL be the highest-priority eligible level, and it SHALL count only if it outranks every set bit of in_service_register (fully nested).
REQ-022 The FSM SHALL have the states IDLE, INT_PENDING, ACK1, WAIT2, ACK2.
REQ-023 The FSM SHALL transition IDLE -> INT_PENDING on the cycle after a winner exists, and interrupt_to_cpu SHALL be registered and high in INT_PENDING, ACK1 and WAIT2.
REQ-024 INT_PENDING SHALL fall back to IDLE if the winner disappears before any INTA falling edge.
REQ-025 The FSM SHALL transition INT_PENDING -> ACK1 on an INTA falling edge (previous sample 1, current sample 0).
REQ-026 On that INTA falling edge, the block SHALL latch the acknowledged level, set its in_service_register bit, and pulse its clear_interrupt_request bit for one cycle.
REQ-027 If no winner exists at that INTA falling edge, the cycle SHALL be spurious: latched level 7, no in_service_register bit set, no clear_interrupt_request pulse.
REQ-028 The FSM SHALL transition ACK1 -> WAIT2 on an INTA rising edge, and data_bus_out_enable SHALL be 0 during the first pulse.
REQ-029 The FSM SHALL transition WAIT2 -> ACK2 on the second INTA falling edge.
REQ-030 In ACK2, data_bus_out SHALL equal {interrupt_vector_base, latched level} with data_bus_out_enable = 1, starting one cycle after the edge and held until INTA rises.
REQ-031 The FSM SHALL transition ACK2 -> IDLE on an INTA rising edge, and interrupt_to_cpu SHALL be 0 in ACK2 and IDLE.
REQ-032 A non-specific EOI SHALL clear the highest-priority set bit of in_service_register.
REQ-033 A specific EOI SHALL clear bit eoi_level, and an EOI with in_service_register = 0 SHALL have no effect.
REQ-034 When an EOI and an acknowledge setting fall in the same cycle, the EOI SHALL be evaluated on the pre-cycle in_service_register and the set SHALL be applied afterwards, so set wins on the same bit.
REQ-035 Requests arriving during ACK1..ACK2 SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-036 Reset SHALL force the FSM to IDLE and set interrupt_to_cpu = 0, in_service_register = 8'h00, clear_interrupt_request = 8'h00, data_bus_out = 8'h00, data_bus_out_enable = 0, latched level = 0, and INTA previous-sample = 1.
REQ-037 An assertion of reset at any point in a sequence SHALL abort the sequence with no further pulses.

Configuration
REQ-038 The macro AUTO_EOI_EN SHALL control auto-EOI support.
REQ-039 With AUTO_EOI_EN defined and auto_eoi_config = 1, the latched level's in_service_register bit SHALL clear on the ACK2 -> IDLE transition.
REQ-040 Without AUTO_EOI_EN, auto_eoi_config SHALL be ignored, and in_service_register bits SHALL clear only via end_of_interrupt.

Verification
REQ-041 The bench SHALL cover: rotate=7, IRR=8'h05, mask=0, two INTA pulses, base=5'h08 -> ISR=8'h01, clear pulse 8'h01, data_bus_out=8'h40 in the second pulse.
REQ-042 The bench SHALL cover: rotate=1, IRR=8'h81 -> winner IR7, ISR=8'h80, vector low bits 3'b111.
REQ-043 The bench SHALL cover: ISR=8'h04, IRR=8'h08 -> interrupt_to_cpu stays 0; then IRR=8'h02 -> interrupt_to_cpu=1.
REQ-044 The bench SHALL cover: IRR dropped to 0 between INT and first INTA -> spurious vector {base,3'b111}, ISR unchanged.
REQ-045 The bench SHALL cover: ISR=8'h05, non-specific EOI -> ISR=8'h04; specific EOI at level 2 -> ISR=8'h00.
REQ-046 The bench SHALL cover: AUTO_EOI_EN defined, auto_eoi_config=1, IR3 acknowledged -> ISR=8'h00 one cycle after the second INTA rises; reset asserted in WAIT2 -> all outputs zero immediately.

Source files
------------

// File: rtl/interrupt_acknowledge_sequencer_if.sv
// CPU-side interrupt acknowledge bus for interrupt_acknowledge_sequencer.
//   interrupt_acknowledge_n : CPU INTA, active low, synchronous to clock
//   interrupt_to_cpu        : INT request to the CPU
//   data_bus_out            : vector byte {T7..T3, level}
//   data_bus_out_enable     : 1 = data_bus_out valid and driven
// Modports: master = CPU side, slave = sequencer side.
interface interrupt_acknowledge_sequencer_if;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;
  logic [7:0] data_bus_out;
  logic       data_bus_out_enable;

  modport master (
    output interrupt_acknowledge_n,
    input  interrupt_to_cpu,
    input  data_bus_out,
    input  data_bus_out_enable
  );

  modport slave (
    input  interrupt_acknowledge_n,
    output interrupt_to_cpu,
    output data_bus_out,
    output data_bus_out_enable
  );
endinterface

// File: rtl/interrupt_acknowledge_sequencer.sv
// 8259-style interrupt acknowledge sequencer with rotating, fully nested
// priority and a two-pulse INTA handshake.
// Ports:
//   clock, reset                : clock (rising edge), async active-high reset
//   cpu_bus (slave)             : INTA in; INT, vector byte and enable out
//   interrupt_request_register  : pending requests IR0..IR7
//   interrupt_mask              : 1 = level masked
//   priority_rotate             : lowest-priority level
//   interrupt_vector_base       : vector bits T7..T3
//   auto_eoi_config             : auto-EOI select (used only with AUTO_EOI_EN)
//   end_of_interrupt            : one-cycle EOI strobe
//   eoi_specific, eoi_level     : specific EOI select and level
//   in_service_register         : levels in service
//   clear_interrupt_request     : one-cycle one-hot clear to the request register
// Build option: define AUTO_EOI_EN to enable auto-EOI on the ACK2 -> IDLE step.
module interrupt_acknowledge_sequencer (
  input  logic       clock,
  input  logic       reset,
  interrupt_acknowledge_sequencer_if.slave cpu_bus,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [2:0] priority_rotate,
  input  logic [4:0] interrupt_vector_base,
  input  logic       auto_eoi_config,
  input  logic       end_of_interrupt,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic [7:0] in_service_register,
  output logic [7:0] clear_interrupt_request
);

  typedef enum logic [2:0] {IDLE, INT_PENDING, ACK1, WAIT2, ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_prev_q;
  logic       int_q, int_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] clr_q, clr_d;
  logic [7:0] dbo_q, dbo_d;
  logic       oe_q, oe_d;
  logic [2:0] level_q, level_d;

  logic       inta_fall, inta_rise;
  logic [7:0] eligible;
  logic [2:0] lvl;
  logic       win_valid, win_ok, isr_busy;
  logic [2:0] win_level, win_rank, isr_top_level, isr_top_rank;
  logic [7:0] isr_set, isr_eoi_clr, auto_clr;

`ifndef AUTO_EOI_EN
  logic unused_auto_eoi;
  assign unused_auto_eoi = auto_eoi_config;
`endif

  assign inta_fall = inta_prev_q & ~cpu_bus.interrupt_acknowledge_n;
  assign inta_rise = ~inta_prev_q & cpu_bus.interrupt_acknowledge_n;

  // Scan from highest priority (rotate+1) downward; rank 0 is highest.
  always_comb begin
    eligible      = interrupt_request_register & ~interrupt_mask;
    lvl           = '0;
    win_valid     = 1'b0;
    win_level     = '0;
    win_rank      = '0;
    isr_busy      = 1'b0;
    isr_top_level = '0;
    isr_top_rank  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      lvl = priority_rotate + 3'(k + 1);
      if (!win_valid && eligible[lvl]) begin
        win_valid = 1'b1;
        win_level = lvl;
        win_rank  = 3'(k);
      end
      if (!isr_busy && isr_q[lvl]) begin
        isr_busy      = 1'b1;
        isr_top_level = lvl;
        isr_top_rank  = 3'(k);
      end
    end
    // Fully nested: a winner must outrank every level already in service.
    win_ok = win_valid && (!isr_busy || (win_rank < isr_top_rank));
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    clr_d    = '0;
    dbo_d    = '0;
    oe_d     = 1'b0;
    isr_set  = '0;
    auto_clr = '0;
    case (state_q)
      IDLE: if (win_ok) state_d = INT_PENDING;
      INT_PENDING: begin
        if (inta_fall) begin
          state_d = ACK1;
          if (win_ok) begin
            level_d            = win_level;
            isr_set[win_level] = 1'b1;
            clr_d[win_level]   = 1'b1;
          end else begin
            level_d = 3'd7;
          end
        end else if (!win_ok) begin
          state_d = IDLE;
        end
      end
      ACK1: if (inta_rise) state_d = WAIT2;
      WAIT2: begin
        if (inta_fall) begin
          state_d = ACK2;
          dbo_d   = {interrupt_vector_base, level_q};
          oe_d    = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d = IDLE;
`ifdef AUTO_EOI_EN
          if (auto_eoi_config) auto_clr[level_q] = 1'b1;
`endif
        end else begin
          dbo_d = dbo_q;
          oe_d  = oe_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI acts on the pre-cycle ISR; a same-cycle acknowledge set wins.
    isr_eoi_clr = '0;
    if (end_of_interrupt) begin
      if (eoi_specific) isr_eoi_clr[eoi_level] = 1'b1;
      else if (isr_busy) isr_eoi_clr[isr_top_level] = 1'b1;
    end
    isr_d = ((isr_q & ~isr_eoi_clr) | isr_set) & ~auto_clr;
    int_d = (state_d == INT_PENDING) || (state_d == ACK1) || (state_d == WAIT2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      inta_prev_q <= 1'b1;
      int_q       <= 1'b0;
      isr_q       <= '0;
      clr_q       <= '0;
      dbo_q       <= '0;
      oe_q        <= 1'b0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= cpu_bus.interrupt_acknowledge_n;
      int_q       <= int_d;
      isr_q       <= isr_d;
      clr_q       <= clr_d;
      dbo_q       <= dbo_d;
      oe_q        <= oe_d;
      level_q     <= level_d;
    end
  end

  assign cpu_bus.interrupt_to_cpu    = int_q;
  assign cpu_bus.data_bus_out        = dbo_q;
  assign cpu_bus.data_bus_out_enable = oe_q;
  assign in_service_register         = isr_q;
  assign clear_interrupt_request     = clr_q;

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
module tb_interrupt_acknowledge_sequencer;
  logic       clock;
  logic       reset;
  logic [7:0] irr;
  logic [7:0] mask;
  logic [2:0] rot;
  logic [4:0] base;
  logic       auto_eoi;
  logic       eoi;
  logic       eoi_spec;
  logic [2:0] eoi_lvl;
  logic [7:0] isr;
  logic [7:0] clr;

  int checks = 0;
  int passed = 0;

  interrupt_acknowledge_sequencer_if bus ();

  interrupt_acknowledge_sequencer dut (
    .clock                      (clock),
    .reset                      (reset),
    .cpu_bus                    (bus),
    .interrupt_request_register (irr),
    .interrupt_mask             (mask),
    .priority_rotate            (rot),
    .interrupt_vector_base      (base),
    .auto_eoi_config            (auto_eoi),
    .end_of_interrupt           (eoi),
    .eoi_specific               (eoi_spec),
    .eoi_level                  (eoi_lvl),
    .in_service_register        (isr),
    .clear_interrupt_request    (clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full two-pulse acknowledge from INT_PENDING back to IDLE.
  task automatic ack_sequence();
    bus.interrupt_acknowledge_n = 1'b0; tick(); tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick(); tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
  endtask

  task automatic send_eoi(input logic spec, input logic [2:0] lv);
    eoi = 1'b1; eoi_spec = spec; eoi_lvl = lv;
    tick();
    eoi = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irr = '0; mask = '0; rot = 3'd7; base = '0; auto_eoi = 1'b0;
    eoi = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0; bus.interrupt_acknowledge_n = 1'b1;
    tick(); tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL rst_int: got %b want 0", bus.interrupt_to_cpu); else passed++;
    checks++; if (isr !== 8'h00) $display("FAIL rst_isr: got %h want 00", isr); else passed++;
    checks++; if (clr !== 8'h00) $display("FAIL rst_clr: got %h want 00", clr); else passed++;
    checks++; if (bus.data_bus_out !== 8'h00) $display("FAIL rst_dbo: got %h want 00", bus.data_bus_out); else passed++;
    checks++; if (bus.data_bus_out_enable !== 1'b0) $display("FAIL rst_oe: got %b want 0", bus.data_bus_out_enable); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_ack();
    rot = 3'd7; irr = 8'h05; base = 5'h08;
    tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL basic_int: got %b want 1", bus.interrupt_to_cpu); else passed++;
    bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (isr !== 8'h01) $display("FAIL basic_isr: got %h want 01", isr); else passed++;
    checks++; if (clr !== 8'h01) $display("FAIL basic_clr: got %h want 01", clr); else passed++;
    checks++; if (bus.data_bus_out_enable !== 1'b0) $display("FAIL basic_oe1: got %b want 0", bus.data_bus_out_enable); else passed++;
    tick();
    checks++; if (clr !== 8'h00) $display("FAIL basic_clr_once: got %h want 00", clr); else passed++;
    bus.interrupt_acknowledge_n = 1'b1; tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL basic_int_wait2: got %b want 1", bus.interrupt_to_cpu); else passed++;
    bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (bus.data_bus_out !== 8'h40) $display("FAIL basic_dbo: got %h want 40", bus.data_bus_out); else passed++;
    checks++; if (bus.data_bus_out_enable !== 1'b1) $display("FAIL basic_oe2: got %b want 1", bus.data_bus_out_enable); else passed++;
    checks++; if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL basic_int_ack2: got %b want 0", bus.interrupt_to_cpu); else passed++;
    tick();
    checks++; if (bus.data_bus_out !== 8'h40) $display("FAIL basic_dbo_hold: got %h want 40", bus.data_bus_out); else passed++;
    bus.interrupt_acknowledge_n = 1'b1; tick();
    checks++; if (bus.data_bus_out_enable !== 1'b0) $display("FAIL basic_oe_off: got %b want 0", bus.data_bus_out_enable); else passed++;
    // IR0 in service blocks the still-pending IR2.
    tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL basic_nested: got %b want 0", bus.interrupt_to_cpu); else passed++;
    irr = 8'h00;
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) $display("FAIL basic_eoi: got %h want 00", isr); else passed++;
  endtask

  task automatic test_rotation();
    rot = 3'd1; irr = 8'h81; base = 5'h08;
    tick();
    bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (isr !== 8'h80) $display("FAIL rot_isr: got %h want 80", isr); else passed++;
    checks++; if (clr !== 8'h80) $display("FAIL rot_clr: got %h want 80", clr); else passed++;
    irr = 8'h00;
    tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (bus.data_bus_out !== 8'h47) $display("FAIL rot_dbo: got %h want 47", bus.data_bus_out); else passed++;
    bus.interrupt_acknowledge_n = 1'b1; tick();
    send_eoi(1'b1, 3'd7);
    checks++; if (isr !== 8'h00) $display("FAIL rot_eoi_spec: got %h want 00", isr); else passed++;
    rot = 3'd7;
  endtask

  task automatic test_nesting();
    irr = 8'h04; tick();
    ack_sequence();
    irr = 8'h08; tick(); tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL nest_block: got %b want 0", bus.interrupt_to_cpu); else passed++;
    irr = 8'h02; tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL nest_higher: got %b want 1", bus.interrupt_to_cpu); else passed++;
    irr = 8'h00; tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL nest_withdraw: got %b want 0", bus.interrupt_to_cpu); else passed++;
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) $display("FAIL nest_eoi: got %h want 00", isr); else passed++;
  endtask

  task automatic test_spurious();
    base = 5'h08; irr = 8'h01; tick();
    irr = 8'h00; bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (isr !== 8'h00) $display("FAIL spur_isr: got %h want 00", isr); else passed++;
    checks++; if (clr !== 8'h00) $display("FAIL spur_clr: got %h want 00", clr); else passed++;
    tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (bus.data_bus_out !== 8'h47) $display("FAIL spur_dbo: got %h want 47", bus.data_bus_out); else passed++;
    bus.interrupt_acknowledge_n = 1'b1; tick();
    checks++; if (isr !== 8'h00) $display("FAIL spur_isr_end: got %h want 00", isr); else passed++;
  endtask

  task automatic test_eoi();
    irr = 8'h04; tick();
    ack_sequence();
    irr = 8'h01; tick();
    ack_sequence();
    irr = 8'h00; tick();
    checks++; if (isr !== 8'h05) $display("FAIL eoi_setup: got %h want 05", isr); else passed++;
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h04) $display("FAIL eoi_nonspec: got %h want 04", isr); else passed++;
    send_eoi(1'b1, 3'd2);
    checks++; if (isr !== 8'h00) $display("FAIL eoi_spec: got %h want 00", isr); else passed++;
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) $display("FAIL eoi_empty: got %h want 00", isr); else passed++;
  endtask

  task automatic test_eoi_collision();
    irr = 8'h04; tick();
    ack_sequence();
    irr = 8'h01; tick();
    // Non-specific EOI clears pre-cycle top (IR2) while IR0 is set.
    bus.interrupt_acknowledge_n = 1'b0; eoi = 1'b1; eoi_spec = 1'b0;
    tick();
    eoi = 1'b0;
    checks++; if (isr !== 8'h01) $display("FAIL collide_isr: got %h want 01", isr); else passed++;
    irr = 8'h00; tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick(); tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) $display("FAIL collide_eoi: got %h want 00", isr); else passed++;
  endtask

  task automatic test_auto_eoi();
    auto_eoi = 1'b1; irr = 8'h08; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick();
    checks++; if (isr !== 8'h08) $display("FAIL aeoi_set: got %h want 08", isr); else passed++;
    irr = 8'h00; tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick(); tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
`ifdef AUTO_EOI_EN
    checks++; if (isr !== 8'h00) $display("FAIL aeoi_clear: got %h want 00", isr); else passed++;
`else
    checks++; if (isr !== 8'h08) $display("FAIL aeoi_ignored: got %h want 08", isr); else passed++;
`endif
    auto_eoi = 1'b0;
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) $display("FAIL aeoi_cleanup: got %h want 00", isr); else passed++;
  endtask

  task automatic test_reset_abort();
    irr = 8'h02; tick();
    bus.interrupt_acknowledge_n = 1'b0; tick(); tick();
    bus.interrupt_acknowledge_n = 1'b1; tick();
    checks++; if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL abort_pre_int: got %b want 1", bus.interrupt_to_cpu); else passed++;
    checks++; if (isr !== 8'h02) $display("FAIL abort_pre_isr: got %h want 02", isr); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL abort_int: got %b want 0", bus.interrupt_to_cpu); else passed++;
    checks++; if (isr !== 8'h00) $display("FAIL abort_isr: got %h want 00", isr); else passed++;
    checks++; if (clr !== 8'h00) $display("FAIL abort_clr: got %h want 00", clr); else passed++;
    checks++; if (bus.data_bus_out !== 8'h00) $display("FAIL abort_dbo: got %h want 00", bus.data_bus_out); else passed++;
    checks++; if (bus.data_bus_out_enable !== 1'b0) $display("FAIL abort_oe: got %b want 0", bus.data_bus_out_enable); else passed++;
    irr = 8'h00; tick();
    reset = 1'b0; tick();
    // The aborted sequence must not resume on the next INTA pulse.
    bus.interrupt_acknowledge_n = 1'b0; tick(); tick();
    checks++; if (bus.data_bus_out_enable !== 1'b0) $display("FAIL abort_no_vector: got %b want 0", bus.data_bus_out_enable); else passed++;
    checks++; if (clr !== 8'h00) $display("FAIL abort_no_clear: got %h want 00", clr); else passed++;
    bus.interrupt_acknowledge_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_rotation();
    test_nesting();
    test_spurious();
    test_eoi();
    test_eoi_collision();
    test_auto_eoi();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
